reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Downstream consumer of the synchronous reset pulse produced by the reset controller. Holds every subsystem reset asserted while the pulse is active, then releases the domains one at a time in a fixed order (memory, video, audio, CPU), with a programmable gap between releases. Video release is gated on the memory controller reporting its initialisation complete. Sits between the reset controller and the GBC core's domain reset inputs.

## Interface
- STAGE_GAP, 16: cycles between consecutive release events; legal range 1–255.
- MEM_TIMEOUT, 1024: cycles to wait for I_MEM_READY before a forced release (only with the timeout feature enabled).
- I_CLK  in  1  system clock; all logic on the rising edge.
- I_ASYNC_RESET_N  in  1  asynchronous, active-low reset. Asserted: every output goes to its reset value immediately.
- I_SYNC_RESET  in  1  active-high reset request from the reset controller, synchronous to I_CLK.
- I_MEM_READY  in  1  memory controller init done, synchronous to I_CLK, level.
- O_MEM_RESET  out  1  memory domain reset, active-high.
- O_VIDEO_RESET  out  1  video domain reset, active-high.
- O_AUDIO_RESET  out  1  audio domain reset, active-high.
- O_CPU_RESET  out  1  CPU domain reset, active-high.
- O_READY  out  1  high once every domain is released.
- O_MEM_TIMEOUT  out  1  sticky flag: memory wait timed out in the last sequence.

## Operation
- Reset values of outputs:
  - All four O_*_RESET = 1.
  - O_READY = 0.
  - O_MEM_TIMEOUT = 0.
  - State = HOLD, counter = 0.
- All outputs are registered. Each release is a single 1→0 transition per sequence.
- States, in order: HOLD, WAIT_MEM, GAP_VIDEO, GAP_AUDIO, GAP_CPU, RUN.
- HOLD
  - The counter increments on each cycle with I_SYNC_RESET=0.
  - On the cycle the counter reaches STAGE_GAP-1: clear O_MEM_RESET and go to WAIT_MEM.
- WAIT_MEM
  - On the first cycle I_MEM_READY=1: go to GAP_VIDEO with counter=0.
  - I_MEM_READY already high on entry counts as that first cycle.
- GAP_VIDEO, GAP_AUDIO, GAP_CPU
  - Each counts STAGE_GAP cycles, then clears O_VIDEO_RESET, O_AUDIO_RESET and O_CPU_RESET respectively.
  - GAP_CPU also sets O_READY on the same edge as the CPU release, then goes to RUN.
- RUN: holds all resets low. I_MEM_READY falling after release is ignored.
- I_SYNC_RESET=1 in any state, including HOLD:
  - Next edge: all four resets = 1, O_READY = 0, state = HOLD, counter = 0.
  - A request arriving mid-sequence restarts the whole sequence; there is no partial resume.
- O_MEM_TIMEOUT:
  - Cleared when a new sequence leaves HOLD.
  - Otherwise held until I_ASYNC_RESET_N.
- Counter: 8 bits for gaps. Timeout counter width = $clog2(MEM_TIMEOUT+1). Both saturate and never wrap.

## Timing
- Let edge E0 be the first rising edge sampling I_SYNC_RESET=0.
  - O_MEM_RESET falls at edge E0+STAGE_GAP-1.
  - With STAGE_GAP=1 it falls at E0.
- Let edge Em be the first edge in WAIT_MEM sampling I_MEM_READY=1.
  - O_VIDEO_RESET falls at Em+STAGE_GAP.
  - O_AUDIO_RESET falls at Em+2·STAGE_GAP.
  - O_CPU_RESET and O_READY change at Em+3·STAGE_GAP.
- Request-to-assert latency: one cycle from the edge sampling I_SYNC_RESET=1.
- I_SYNC_RESET and I_MEM_READY carry no synchroniser; both must be I_CLK-domain signals.
- Asynchronous reset assertion affects outputs immediately. Release is synchronised externally; the block does not re-synchronise I_ASYNC_RESET_N.

## Configuration
- RESET_SEQ_TIMEOUT_EN defined:
  - WAIT_MEM counts cycles.
  - After MEM_TIMEOUT cycles without I_MEM_READY: set O_MEM_TIMEOUT and proceed to GAP_VIDEO as if ready.
- Undefined:
  - WAIT_MEM waits indefinitely.
  - The timeout counter is absent and O_MEM_TIMEOUT is tied to 0.

## Structure
- Package reset_seq_pkg holds:
  - the state enum (HOLD, WAIT_MEM, GAP_VIDEO, GAP_AUDIO, GAP_CPU, RUN);
  - default constants for STAGE_GAP and MEM_TIMEOUT;
  - the domain-index constants.
- Sub-module reset_seq_timer: loadable up-counter with terminal-count output, reused for the gap and timeout counts.
- FSM and output registers live in the top module.

## Test plan
Unless stated otherwise: STAGE_GAP=4, MEM_TIMEOUT=20, I_MEM_READY tied high.
- Async reset released with I_SYNC_RESET=0:
  - Required response: all resets high, then MEM falls at E0+3.
  - Video at +4 from Em, audio at +8, CPU and O_READY at +12.
- I_SYNC_RESET pulsed for 5 cycles while in RUN: all resets high one cycle after the first high sample, then the full sequence repeats from the falling edge of the pulse.
- I_MEM_READY held low for 50 cycles after MEM release (timeout disabled) → video stays in reset; it releases 4 cycles after I_MEM_READY rises.
- Build with RESET_SEQ_TIMEOUT_EN, I_MEM_READY stuck at 0:
  - After 20 cycles in WAIT_MEM, O_MEM_TIMEOUT=1.
  - Video releases 4 cycles later; the flag stays set through RUN.
- I_SYNC_RESET asserted during GAP_AUDIO → memory and video reassert next cycle, O_READY stays 0, and the sequence restarts.
- I_ASYNC_RESET_N asserted mid-sequence with no clock edge → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the subsystem reset sequencer.
package reset_seq_pkg;

  // Sequencer states, in release order.
  typedef enum logic [2:0] {
    HOLD,
    WAIT_MEM,
    GAP_VIDEO,
    GAP_AUDIO,
    GAP_CPU,
    RUN
  } seq_state_e;

  // Default release gap and memory-init timeout, in I_CLK cycles.
  localparam int STAGE_GAP_DEF   = 16;
  localparam int MEM_TIMEOUT_DEF = 1024;

  // Width of the gap counter; gaps are limited to 1..255.
  localparam int GAP_W = 8;

  // Bit positions of each domain inside the reset vector.
  localparam int NUM_DOMAINS = 4;
  localparam int DOM_MEM     = 0;
  localparam int DOM_VIDEO   = 1;
  localparam int DOM_AUDIO   = 2;
  localparam int DOM_CPU     = 3;

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable saturating up-counter with a terminal-count compare.
// Used for both the inter-release gaps and the memory-init timeout.
module reset_seq_timer #(
  parameter int W = 8
) (
  input  logic         I_CLK,
  input  logic         I_ASYNC_RESET_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count_q;

  // Load has priority over counting; the count sticks at all-ones rather than wrapping.
  always_ff @(posedge I_CLK or negedge I_ASYNC_RESET_N) begin
    if (!I_ASYNC_RESET_N) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc = (count_q == term);

endmodule

// File: rtl/reset_sequencer.sv
// Subsystem reset sequencer: holds all domain resets while the controller's
// synchronous reset pulse is active, then releases memory, video, audio and
// CPU in order with STAGE_GAP cycles between releases. Video waits for the
// memory controller to report init done.
// Optional feature macro: RESET_SEQ_TIMEOUT_EN -- bounds the memory wait to
// MEM_TIMEOUT cycles and raises the sticky O_MEM_TIMEOUT flag on expiry.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int STAGE_GAP   = STAGE_GAP_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic I_CLK,
  input  logic I_ASYNC_RESET_N,
  input  logic I_SYNC_RESET,
  input  logic I_MEM_READY,
  output logic O_MEM_RESET,
  output logic O_VIDEO_RESET,
  output logic O_AUDIO_RESET,
  output logic O_CPU_RESET,
  output logic O_READY,
  output logic O_MEM_TIMEOUT
);

  seq_state_e             state_q, state_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic                   tmo_q, tmo_d;
  logic                   gap_load, gap_en, gap_tc;
  logic                   tmo_tc;

  reset_seq_timer #(.W(GAP_W)) u_gap_timer (
    .I_CLK           (I_CLK),
    .I_ASYNC_RESET_N (I_ASYNC_RESET_N),
    .load            (gap_load),
    .load_val        ('0),
    .en              (gap_en),
    .term            (GAP_W'(STAGE_GAP - 1)),
    .tc              (gap_tc)
  );

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  logic tmo_load, tmo_en;

  assign tmo_load = (state_q != WAIT_MEM);
  assign tmo_en   = (state_q == WAIT_MEM) && !I_MEM_READY;

  reset_seq_timer #(.W(TMO_W)) u_tmo_timer (
    .I_CLK           (I_CLK),
    .I_ASYNC_RESET_N (I_ASYNC_RESET_N),
    .load            (tmo_load),
    .load_val        ('0),
    .en              (tmo_en),
    .term            (TMO_W'(MEM_TIMEOUT - 1)),
    .tc              (tmo_tc)
  );
`else
  // The memory wait never expires in this build; the compare is constant false.
  assign tmo_tc = (MEM_TIMEOUT < 0);
`endif

  // State and registered outputs; async reset puts every domain back in reset.
  always_ff @(posedge I_CLK or negedge I_ASYNC_RESET_N) begin
    if (!I_ASYNC_RESET_N) begin
      state_q <= HOLD;
      rst_q   <= '1;
      ready_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state, next outputs and gap-counter control; a sync request beats everything.
  always_comb begin
    state_d  = state_q;
    rst_d    = rst_q;
    ready_d  = ready_q;
    tmo_d    = tmo_q;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    if (I_SYNC_RESET) begin
      state_d  = HOLD;
      rst_d    = '1;
      ready_d  = 1'b0;
      gap_load = 1'b1;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (gap_tc) begin
            rst_d[DOM_MEM] = 1'b0;
            tmo_d          = 1'b0;
            gap_load       = 1'b1;
            state_d        = WAIT_MEM;
          end else begin
            gap_en = 1'b1;
          end
        end
        WAIT_MEM: begin
          if (I_MEM_READY) begin
            gap_load = 1'b1;
            state_d  = GAP_VIDEO;
          end else if (tmo_tc) begin
            tmo_d    = 1'b1;
            gap_load = 1'b1;
            state_d  = GAP_VIDEO;
          end
        end
        GAP_VIDEO: begin
          if (gap_tc) begin
            rst_d[DOM_VIDEO] = 1'b0;
            gap_load         = 1'b1;
            state_d          = GAP_AUDIO;
          end else begin
            gap_en = 1'b1;
          end
        end
        GAP_AUDIO: begin
          if (gap_tc) begin
            rst_d[DOM_AUDIO] = 1'b0;
            gap_load         = 1'b1;
            state_d          = GAP_CPU;
          end else begin
            gap_en = 1'b1;
          end
        end
        GAP_CPU: begin
          if (gap_tc) begin
            rst_d[DOM_CPU] = 1'b0;
            ready_d        = 1'b1;
            gap_load       = 1'b1;
            state_d        = RUN;
          end else begin
            gap_en = 1'b1;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d  = HOLD;
          rst_d    = '1;
          ready_d  = 1'b0;
          gap_load = 1'b1;
        end
      endcase
    end
  end

  assign O_MEM_RESET   = rst_q[DOM_MEM];
  assign O_VIDEO_RESET = rst_q[DOM_VIDEO];
  assign O_AUDIO_RESET = rst_q[DOM_AUDIO];
  assign O_CPU_RESET   = rst_q[DOM_CPU];
  assign O_READY       = ready_q;
  assign O_MEM_TIMEOUT = tmo_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios followed by random sync-reset
// and memory-ready activity, all checked cycle by cycle against an
// edge-arithmetic model of the release timeline.
module tb_reset_sequencer;

  localparam int G  = 4;
  localparam int MT = 20;

  logic clk;
  logic rst_n;
  logic sync_rst;
  logic mem_ready;
  logic mem_rst, vid_rst, aud_rst, cpu_rst, ready, mem_tmo;

  reset_sequencer #(.STAGE_GAP(G), .MEM_TIMEOUT(MT)) dut (
    .I_CLK           (clk),
    .I_ASYNC_RESET_N (rst_n),
    .I_SYNC_RESET    (sync_rst),
    .I_MEM_READY     (mem_ready),
    .O_MEM_RESET     (mem_rst),
    .O_VIDEO_RESET   (vid_rst),
    .O_AUDIO_RESET   (aud_rst),
    .O_CPU_RESET     (cpu_rst),
    .O_READY         (ready),
    .O_MEM_TIMEOUT   (mem_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: edge index k; e0 = first edge sampling sync low, mrel = memory
  // release edge, em = edge the memory wait ends (-1 means not yet).
  int k    = 0;
  int e0   = -1;
  int mrel = -1;
  int em   = -1;
  bit tmo_m = 1'b0;

  task automatic check_vec(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got=%b exp=%b (mem,vid,aud,cpu,rdy,tmo)", tag, k, got, exp);
    end
  endtask

  function automatic logic [5:0] model_out();
    bit rel_v, rel_a, rel_c;
    rel_v = (em >= 0) && (k >= em + G);
    rel_a = (em >= 0) && (k >= em + 2*G);
    rel_c = (em >= 0) && (k >= em + 3*G);
    return {(mrel < 0), !rel_v, !rel_a, !rel_c, rel_c, tmo_m};
  endfunction

  task automatic model_async_reset();
    e0 = -1; mrel = -1; em = -1; tmo_m = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit r);
    k++;
    if (s) begin
      e0 = -1; mrel = -1; em = -1;
    end else begin
      if (e0 < 0) e0 = k;
      if (mrel < 0) begin
        if (k == e0 + G - 1) begin
          mrel  = k;
          tmo_m = 1'b0;
        end
      end else if (em < 0) begin
        if (r) em = k;
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (k - mrel == MT) begin
          em    = k;
          tmo_m = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic step(input string tag, input bit s, input bit r);
    sync_rst  = s;
    mem_ready = r;
    @(posedge clk);
    model_edge(s, r);
    #1;
    check_vec(tag, {mem_rst, vid_rst, aud_rst, cpu_rst, ready, mem_tmo}, model_out());
  endtask

  initial begin
    bit r;
    rst_n     = 1'b0;
    sync_rst  = 1'b0;
    mem_ready = 1'b1;
    #12;
    check_vec("reset_state", {mem_rst, vid_rst, aud_rst, cpu_rst, ready, mem_tmo}, 6'b111100);
    rst_n = 1'b1;

    // Power-up sequence with memory ready from the start.
    for (int i = 0; i < 24; i++) step("powerup", 1'b0, 1'b1);

    // Five-cycle sync request while running, then the full sequence again.
    for (int i = 0; i < 5; i++) step("sync_run", 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) step("resequence", 1'b0, 1'b1);

    // Memory never reports ready for a long stretch, then comes up.
    step("mem_wait_req", 1'b1, 1'b0);
    for (int i = 0; i < 54; i++) step("mem_wait", 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("mem_late", 1'b0, 1'b1);

    // Sync request landing in the audio gap.
    step("audio_req", 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step("to_audio", 1'b0, 1'b1);
    step("audio_abort", 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step("after_abort", 1'b0, 1'b1);

    // Async reset mid-sequence, checked with no clock edge in between.
    step("async_req", 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step("to_async", 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    model_async_reset();
    check_vec("async_assert", {mem_rst, vid_rst, aud_rst, cpu_rst, ready, mem_tmo}, 6'b111100);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step("after_async", 1'b0, 1'b1);

    // Random sync requests and memory-ready activity.
    r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) r = ~r;
      step("random", ($urandom_range(0, 39) == 0), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
